// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix tile fetch engine.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - get_address: linear row-major address of element (row, col)
//   - elem_lsb:    bit offset of element [i][j] inside a flat tile word
package matrix_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  // Callers truncate the result to their address width, so wrap-around past
  // the top of memory falls out of the modular arithmetic for free.
  function automatic logic [31:0] get_address(input logic [31:0] row,
                                              input logic [31:0] col,
                                              input logic [31:0] cols,
                                              input logic [31:0] base);
    logic [31:0] prod;
    prod = row * cols;
    return base + prod + col;
  endfunction

  function automatic int elem_lsb(input int i, input int j,
                                  input int tile, input int data_w);
    return (i * tile + j) * data_w;
  endfunction

endpackage

// File: rtl/matrix_tile_fetch_tile_buffer.sv
// tile_buffer: TILE x TILE array of DATA_W registers.
// Ports:
//   clock, reset  - clock and asynchronous active-low reset
//   i_clear       - synchronous clear of every element
//   i_we          - write enable for element [i_row][i_col]
//   i_row, i_col  - write coordinates
//   i_data        - write data
//   o_flat        - all elements; [i][j] at bits (i*TILE+j)*DATA_W +: DATA_W
module tile_buffer
  import matrix_pkg::*;
#(
  parameter int TILE   = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_clear,
  input  logic                        i_we,
  input  logic [IDX_W-1:0]            i_row,
  input  logic [IDX_W-1:0]            i_col,
  input  logic [DATA_W-1:0]           i_data,
  output logic [TILE*TILE*DATA_W-1:0] o_flat
);

  logic [DATA_W-1:0] r_elem [TILE][TILE];

  // NOTE: this array is small and directly drives a module output, so it is
  // reset like any other register; a large RAM would normally be left unreset.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TILE; i++)
        for (int j = 0; j < TILE; j++)
          r_elem[i][j] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < TILE; i++)
        for (int j = 0; j < TILE; j++)
          r_elem[i][j] <= '0;
    end else if (i_we) begin
      r_elem[i_row][i_col] <= i_data;
    end
  end

  for (genvar gi = 0; gi < TILE; gi++) begin : g_row
    for (genvar gj = 0; gj < TILE; gj++) begin : g_col
      assign o_flat[elem_lsb(gi, gj, TILE, DATA_W) +: DATA_W] = r_elem[gi][gj];
    end
  end

endmodule

// File: rtl/matrix_tile_fetch.sv
// matrix_tile_fetch: reads one TILE x TILE tile of a row-major ROWS x COLS
// matrix from single-port memory, zero-pads out-of-range elements, optionally
// transposes, and presents the tile as one flat word under valid/ready.
// Ports:
//   clock, reset          - clock and asynchronous active-low reset
//   start                 - fetch request, sampled only when idle
//   base_addr, rows, cols - matrix placement and shape
//   tile_row, tile_col    - tile index; transpose - store tile transposed
//   mem_addr, mem_read    - memory request; mem_rdata valid the cycle after
//   tile_data, tile_valid, tile_ready - tile output handshake
//   busy, error, done     - status: not idle, rejected request, tile taken
module matrix_tile_fetch
  import matrix_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 8,
  parameter int TILE   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [DIM_W-1:0]            rows,
  input  logic [DIM_W-1:0]            cols,
  input  logic [DIM_W-1:0]            tile_row,
  input  logic [DIM_W-1:0]            tile_col,
  input  logic                        transpose,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_read,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [TILE*TILE*DATA_W-1:0] tile_data,
  output logic                        tile_valid,
  input  logic                        tile_ready,
  output logic                        busy,
  output logic                        error,
  output logic                        done
);

  localparam int IDX_W  = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int WIDE_W = 2 * DIM_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TILE - 1);

  logic [1:0]        r_state;
  logic              r_check;      // request latched, validity checked this cycle
  logic [ADDR_W-1:0] r_base;
  logic [DIM_W-1:0]  r_rows;
  logic [DIM_W-1:0]  r_cols;
  logic [DIM_W-1:0]  r_tile_row;
  logic [DIM_W-1:0]  r_tile_col;
  logic              r_transpose;
  logic [IDX_W-1:0]  r_i;
  logic [IDX_W-1:0]  r_j;
  logic              r_pend;       // a read issued last cycle returns data now
  logic [IDX_W-1:0]  r_pend_row;
  logic [IDX_W-1:0]  r_pend_col;
  logic              r_done;

  logic [WIDE_W-1:0] w_row_org;
  logic [WIDE_W-1:0] w_col_org;
  logic [WIDE_W-1:0] w_r;
  logic [WIDE_W-1:0] w_c;
  logic              w_in_range;
  logic              w_invalid;
  logic [ADDR_W-1:0] w_addr;
  logic [IDX_W-1:0]  w_dst_row;
  logic [IDX_W-1:0]  w_dst_col;
  logic              w_clear;

  assign w_row_org  = WIDE_W'(r_tile_row) * WIDE_W'(TILE);
  assign w_col_org  = WIDE_W'(r_tile_col) * WIDE_W'(TILE);
  assign w_r        = w_row_org + WIDE_W'(r_i);
  assign w_c        = w_col_org + WIDE_W'(r_j);
  assign w_in_range = (w_r < WIDE_W'(r_rows)) && (w_c < WIDE_W'(r_cols));

  assign w_invalid = (r_rows == '0) || (r_cols == '0) ||
                     (w_row_org >= WIDE_W'(r_rows)) ||
                     (w_col_org >= WIDE_W'(r_cols));

  assign w_addr = ADDR_W'(get_address(32'(w_r), 32'(w_c),
                                      32'(r_cols), 32'(r_base)));

  assign w_dst_row = r_transpose ? r_j : r_i;
  assign w_dst_col = r_transpose ? r_i : r_j;

  // Padding is never written explicitly: the buffer is cleared as the fetch
  // starts, which leaves the single write port free for returning read data.
  assign w_clear = r_check && !w_invalid;

  assign mem_read   = (r_state == S_FETCH) && w_in_range;
  assign mem_addr   = mem_read ? w_addr : '0;
  assign tile_valid = (r_state == S_PRESENT);
  assign busy       = (r_state != S_IDLE);
  assign error      = r_check && w_invalid;
  assign done       = r_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_check     <= 1'b0;
      r_base      <= '0;
      r_rows      <= '0;
      r_cols      <= '0;
      r_tile_row  <= '0;
      r_tile_col  <= '0;
      r_transpose <= 1'b0;
      r_i         <= '0;
      r_j         <= '0;
      r_pend      <= 1'b0;
      r_pend_row  <= '0;
      r_pend_col  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_check <= 1'b0;
      r_done  <= 1'b0;
      r_pend  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_check) begin
            if (!w_invalid) begin
              r_state <= S_FETCH;
              r_i     <= '0;
              r_j     <= '0;
            end
          end else if (start) begin
            r_base      <= base_addr;
            r_rows      <= rows;
            r_cols      <= cols;
            r_tile_row  <= tile_row;
            r_tile_col  <= tile_col;
            r_transpose <= transpose;
            r_check     <= 1'b1;
          end
        end
        S_FETCH: begin
          r_pend     <= mem_read;
          r_pend_row <= w_dst_row;
          r_pend_col <= w_dst_col;
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) r_state <= S_DRAIN;
            else             r_i     <= r_i + IDX_W'(1);
          end else begin
            r_j <= r_j + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          r_state <= S_PRESENT;
        end
        S_PRESENT: begin
          if (tile_ready) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  tile_buffer #(
    .TILE   (TILE),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_tile_buffer (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_clear),
    .i_we    (r_pend),
    .i_row   (r_pend_row),
    .i_col   (r_pend_col),
    .i_data  (mem_rdata),
    .o_flat  (tile_data)
  );

endmodule

// File: doc/matrix_tile_fetch.md
Name: matrix_tile_fetch

Overview:
- Fetches one TILE x TILE tile of a row-major ROWS x COLS matrix from the shared single-port memory.
- Zero-pads out-of-range elements and optionally transposes the tile.
- Presents the tile as one flat word under a valid/ready handshake.
- Generalised A/B read-and-extend engine feeding the tile multiplier; one instance per operand.

Parameters:
DATA_W, 32, element width in bits
ADDR_W, 8, memory address width
DIM_W, 8, width of matrix dimension and tile index inputs
TILE, 4, tile edge length; legal range is 2 to 8

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  request a fetch; sampled only in S_IDLE
base_addr  in  ADDR_W  address of element M[0][0]
rows  in  DIM_W  matrix row count
cols  in  DIM_W  matrix column count
tile_row  in  DIM_W  tile row index
tile_col  in  DIM_W  tile column index
transpose  in  1  store the tile transposed
mem_addr  out  ADDR_W  memory address
mem_read  out  1  memory read strobe
mem_rdata  in  DATA_W  memory read data, valid on the cycle after mem_read
tile_data  out  TILE*TILE*DATA_W  tile contents; element [i][j] is at bits (i*TILE+j)*DATA_W +: DATA_W
tile_valid  out  1  tile_data is valid
tile_ready  in  1  consumer accepts the tile
busy  out  1  high whenever state is not S_IDLE
error  out  1  one-cycle pulse on a rejected request
done  out  1  one-cycle pulse on tile handshake completion

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state to S_IDLE;
  - all outputs, the counters and the tile buffer to 0.
  - Reset mid-fetch or mid-present aborts the operation; no partial tile is ever presented.
- The inputs base_addr, rows, cols, tile_row, tile_col and transpose are latched when start is accepted. Later changes to them have no effect.
- States:
  - S_IDLE:
    - start is accepted only here; start in any other state is ignored.
    - The request is invalid if rows==0, cols==0, tile_row*TILE>=rows, or tile_col*TILE>=cols.
    - Invalid: error pulses high on the next cycle and the state stays S_IDLE. No memory access is made.
    - Valid: go to S_FETCH with i=0, j=0.
  - S_FETCH: visits exactly one element (i,j) per cycle in row-major order, i being the outer index.
    - Source coordinates: r = tile_row*TILE+i, c = tile_col*TILE+j.
    - If r<rows and c<cols: mem_read=1 and mem_addr = base_addr + r*cols + c, truncated to ADDR_W. Wrap-around past 2^ADDR_W is permitted and not flagged.
    - Otherwise: mem_read=0 and the destination element is written 0.
    - Destination is buf[i][j], or buf[j][i] when transpose=1.
    - Read data returned on the next cycle is written to the destination remembered from the issue cycle, held in a one-deep pipeline register.
    - After element (TILE-1,TILE-1), go to S_DRAIN.
  - S_DRAIN: one cycle. Captures the final read if one is pending. mem_read=0. Then go to S_PRESENT.
  - S_PRESENT: tile_valid=1 and tile_data is held stable.
    - When tile_valid and tile_ready are both high at a clock edge, done pulses and the state returns to S_IDLE.
    - tile_valid deasserts on that same edge.
- Latency, with start accepted at edge k:
  - fetch cycles are k+1 through k+TILE*TILE;
  - tile_valid rises at edge k+TILE*TILE+2, independent of padding.
- mem_read is high only in S_FETCH for in-range elements.
- The memory read count per tile equals the number of in-range elements.
- The tile buffer keeps its contents after the handshake until the next fetch overwrites it.
- tile_ready has no effect outside S_PRESENT.
- Arithmetic: r*cols is computed at 2*DIM_W width, then the sum is truncated to ADDR_W.

Decomposition:
- Package matrix_pkg holds:
  - the state localparams (S_IDLE, S_FETCH, S_DRAIN, S_PRESENT);
  - the address function get_address(row, col, cols, base);
  - the flat-index helper elem_lsb(i, j, TILE, DATA_W).
- One sub-module, tile_buffer: a TILE x TILE x DATA_W register array with one write port (i, j, data, we), a synchronous clear, and a flat read-out.
- The FSM, counters and address generation live in matrix_tile_fetch.

Test Plan:
- Full in-range tile: memory holds M[r][c]=16*r+c, base=0x00, rows=cols=4, tile (0,0), transpose=0 -> 16 reads at addresses 0x00..0x0F in order; tile_valid at k+18; buf[2][3]=0x23.
- Padded edge tile: rows=6, cols=5, base=0x10, tile (1,1) -> exactly 2 reads, at 0x28 and 0x2D; buf[0][0]=0x44, buf[1][0]=0x54, all other elements 0; tile_valid still at k+18.
- Transpose: same setup as the full in-range tile with transpose=1 -> buf[2][3]=0x32 and buf[3][2]=0x23.
- Reject: rows=3, cols=4, tile (1,0) -> error high for exactly 1 cycle, mem_read never asserted, busy stays 0. A second request with cols=0 is also rejected.
- Backpressure and ignored start: tile_ready held low for 10 cycles in S_PRESENT -> tile_data stable and tile_valid high throughout. A start pulsed during this window is ignored. Raising tile_ready gives a done pulse and S_IDLE.
- Reset mid-fetch: assert reset at fetch cycle 7 -> mem_read, busy, tile_valid and tile_data all 0 immediately. After release, a new fetch completes normally.
